// File: rtl/flu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : flu_issue_pkg
//  Purpose  : Shared types and constants for the FLU issue controller:
//             target-unit codes, the operand bundle and the helper that
//             recognises single-cycle multiplier operations.
//             fu_data_t and TRANS_ID_BITS follow the ariane_pkg layout
//             (operation, operands, immediate, trans_id).
//  Macros   : none (FLU_ISSUE_VALU_EN is consumed by flu_strobe_dec)
//  Revision : 1.0 - initial release
// ============================================================================
package flu_issue_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 3;

    // Multiplier result is registered once before it reaches the shared
    // writeback port; the collision window in the controller is one cycle.
    localparam int unsigned FLU_MULT_LAT  = 1;

    typedef enum logic [2:0] {
        FLU_ALU    = 3'd0,
        FLU_BRANCH = 3'd1,
        FLU_CSR    = 3'd2,
        FLU_MULT   = 3'd3,
        FLU_VALU   = 3'd4
    } flu_sel_t;

    // Operation codes relevant to this block. Only the MUL family is
    // distinguished; everything else passes through untouched.
    localparam logic [7:0] OP_ADD    = 8'd0;
    localparam logic [7:0] OP_MUL    = 8'd40;
    localparam logic [7:0] OP_MULH   = 8'd41;
    localparam logic [7:0] OP_MULHSU = 8'd42;
    localparam logic [7:0] OP_MULHU  = 8'd43;
    localparam logic [7:0] OP_MULW   = 8'd44;
    localparam logic [7:0] OP_DIV    = 8'd45;
    localparam logic [7:0] OP_DIVU   = 8'd46;
    localparam logic [7:0] OP_REM    = 8'd47;
    localparam logic [7:0] OP_REMU   = 8'd48;

    typedef struct packed {
        logic [7:0]               operation;
        logic [XLEN-1:0]          operand_a;
        logic [XLEN-1:0]          operand_b;
        logic [XLEN-1:0]          imm;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } fu_data_t;

    // MUL family ops complete in FLU_MULT_LAT cycles and therefore claim the
    // writeback port in the following cycle; divisions do not.
    function automatic logic is_mul_op(input logic [7:0] op);
        return (op >= OP_MUL) && (op <= OP_MULW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flu_strobe_dec.sv
`default_nettype none
// ============================================================================
//  Module   : flu_strobe_dec
//  Purpose  : Combinational one-hot decode of the staged unit code, qualified
//             by fire, into the five FLU valid strobes and an unsupported
//             flag for codes whose unit is absent (or illegal codes 5-7).
//  Ports    : fire_i          - staged op leaves the issue register
//             sel_i[2:0]      - target unit code (flu_sel_t encoding)
//             *_valid_o       - one-hot unit strobes
//             unsupported_o   - op fired toward an absent/illegal unit
//  Macros   : FLU_ISSUE_VALU_EN - present VALU; otherwise VALU ops are
//             reported as unsupported and valu_valid_o stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module flu_strobe_dec
    import flu_issue_pkg::*;
(
    input  logic       fire_i,
    input  logic [2:0] sel_i,
    output logic       alu_valid_o,
    output logic       branch_valid_o,
    output logic       csr_valid_o,
    output logic       mult_valid_o,
    output logic       valu_valid_o,
    output logic       unsupported_o
);

    always_comb begin
        alu_valid_o    = 1'b0;
        branch_valid_o = 1'b0;
        csr_valid_o    = 1'b0;
        mult_valid_o   = 1'b0;
        valu_valid_o   = 1'b0;
        unsupported_o  = 1'b0;
        if (fire_i) begin
            case (sel_i)
                FLU_ALU:    alu_valid_o    = 1'b1;
                FLU_BRANCH: branch_valid_o = 1'b1;
                FLU_CSR:    csr_valid_o    = 1'b1;
                FLU_MULT:   mult_valid_o   = 1'b1;
`ifdef FLU_ISSUE_VALU_EN
                FLU_VALU:   valu_valid_o   = 1'b1;
`else
                // The scoreboard still has to retire or trap these.
                FLU_VALU:   unsupported_o  = 1'b1;
`endif
                default:    unsupported_o  = 1'b1;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/flu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flu_issue_ctrl
//  Purpose  : Issue-side driver of the fixed-latency-unit port. A single
//             entry issue register accepts one op per cycle and raises one
//             FLU strobe with the operand bundle when the FLU is ready and
//             the multiplier result does not own the writeback port.
//  Ports    : clk_i, rst_ni (synchronous, active-low)
//             flush_i                 - drop staged op, block issue this cycle
//             issue_valid_i/_ready_o  - issue handshake
//             issue_fu_data_i         - operation, operands, trans_id
//             issue_sel_i[2:0]        - target unit code
//             flu_ready_i             - FLU can take an op
//             fu_data_o               - staged bundle, '0 when empty
//             alu/branch/csr/mult/valu_valid_o - one-hot strobes
//             unsupported_o/_trans_id_o - dropped op for an absent unit
//             stall_cnt_o             - cycles staged but not fired
//  Macros   : FLU_ISSUE_VALU_EN - enables the VALU strobe (see flu_strobe_dec)
//  Revision : 1.0 - initial release
// ============================================================================
module flu_issue_ctrl
    import flu_issue_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_valid_i,
    output logic                     issue_ready_o,
    input  fu_data_t                 issue_fu_data_i,
    input  logic [2:0]               issue_sel_i,
    input  logic                     flu_ready_i,
    output fu_data_t                 fu_data_o,
    output logic                     alu_valid_o,
    output logic                     branch_valid_o,
    output logic                     csr_valid_o,
    output logic                     mult_valid_o,
    output logic                     valu_valid_o,
    output logic                     unsupported_o,
    output logic [TRANS_ID_BITS-1:0] unsupported_trans_id_o,
    output logic [STALL_CNT_W-1:0]   stall_cnt_o
);

    logic                   r_stage_valid;
    fu_data_t               r_stage_data;
    logic [2:0]             r_stage_sel;
    logic                   r_mult_wb;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_collision;
    logic w_fire;
    logic w_accept;
    logic w_unsupported;

    // The registered multiplier result owns writeback this cycle; only a
    // further multiply may proceed since it lands one cycle later.
    assign w_collision = r_mult_wb && (r_stage_sel != FLU_MULT);

    // Flush suppresses fire so no strobe escapes in the flush cycle.
    assign w_fire   = r_stage_valid && flu_ready_i && !w_collision && !flush_i;
    assign w_accept = issue_valid_i && issue_ready_o;

    assign issue_ready_o = !flush_i && (!r_stage_valid || w_fire);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_stage_valid <= 1'b0;
            r_stage_data  <= '0;
            r_stage_sel   <= FLU_ALU;
            r_mult_wb     <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            r_mult_wb <= w_fire && (r_stage_sel == FLU_MULT)
                         && is_mul_op(r_stage_data.operation);

            if (flush_i) begin
                r_stage_valid <= 1'b0;
            end else if (w_accept) begin
                r_stage_valid <= 1'b1;
                r_stage_data  <= issue_fu_data_i;
                r_stage_sel   <= issue_sel_i;
            end else if (w_fire) begin
                r_stage_valid <= 1'b0;
            end

            // Free-running statistic: wraps, survives flush.
            if (r_stage_valid && !w_fire && !flush_i) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    flu_strobe_dec u_strobe_dec (
        .fire_i         (w_fire),
        .sel_i          (r_stage_sel),
        .alu_valid_o    (alu_valid_o),
        .branch_valid_o (branch_valid_o),
        .csr_valid_o    (csr_valid_o),
        .mult_valid_o   (mult_valid_o),
        .valu_valid_o   (valu_valid_o),
        .unsupported_o  (w_unsupported)
    );

    assign unsupported_o          = w_unsupported;
    assign unsupported_trans_id_o = w_unsupported ? r_stage_data.trans_id : '0;

    assign fu_data_o   = r_stage_valid ? r_stage_data : '0;
    assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flu_issue_ctrl
//  Purpose  : Directed, table-driven bench for flu_issue_ctrl. Each table row
//             is one cycle of inputs plus the outputs expected in that same
//             cycle (sampled 1 time unit after the falling edge).
//  Macros   : FLU_ISSUE_VALU_EN - selects the VALU expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flu_issue_ctrl;
    import flu_issue_pkg::*;

    logic                     clk_i = 1'b0;
    logic                     rst_ni = 1'b0;
    logic                     flush_i = 1'b0;
    logic                     issue_valid_i = 1'b0;
    logic                     issue_ready_o;
    fu_data_t                 issue_fu_data_i = '0;
    logic [2:0]               issue_sel_i = 3'd0;
    logic                     flu_ready_i = 1'b0;
    fu_data_t                 fu_data_o;
    logic                     alu_valid_o, branch_valid_o, csr_valid_o;
    logic                     mult_valid_o, valu_valid_o, unsupported_o;
    logic [TRANS_ID_BITS-1:0] unsupported_trans_id_o;
    logic [31:0]              stall_cnt_o;

    flu_issue_ctrl #(.STALL_CNT_W(32)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .flush_i                (flush_i),
        .issue_valid_i          (issue_valid_i),
        .issue_ready_o          (issue_ready_o),
        .issue_fu_data_i        (issue_fu_data_i),
        .issue_sel_i            (issue_sel_i),
        .flu_ready_i            (flu_ready_i),
        .fu_data_o              (fu_data_o),
        .alu_valid_o            (alu_valid_o),
        .branch_valid_o         (branch_valid_o),
        .csr_valid_o            (csr_valid_o),
        .mult_valid_o           (mult_valid_o),
        .valu_valid_o           (valu_valid_o),
        .unsupported_o          (unsupported_o),
        .unsupported_trans_id_o (unsupported_trans_id_o),
        .stall_cnt_o            (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [4:0] S_NO  = 5'b00000;
    localparam logic [4:0] S_ALU = 5'b10000;
    localparam logic [4:0] S_BR  = 5'b01000;
    localparam logic [4:0] S_CSR = 5'b00100;
    localparam logic [4:0] S_MUL = 5'b00010;
`ifdef FLU_ISSUE_VALU_EN
    localparam logic [4:0] S_VALU = 5'b00001;
    localparam logic       U_VALU = 1'b0;
`else
    localparam logic [4:0] S_VALU = 5'b00000;
    localparam logic       U_VALU = 1'b1;
`endif

    typedef struct {
        logic       fl;
        logic       iv;
        logic [2:0] sel;
        logic [7:0] op;
        logic [2:0] id;
        logic       rdy;
        logic [4:0] e_stb;
        logic       e_uns;
        logic       e_rdy;
        logic [2:0] e_id;   // 0 means stage expected empty
        int         e_stall;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic vec_t mk(input logic fl, input logic iv, input logic [2:0] sel,
                                input logic [7:0] op, input logic [2:0] id, input logic rdy,
                                input logic [4:0] e_stb, input logic e_uns, input logic e_rdy,
                                input logic [2:0] e_id, input int e_stall);
        vec_t v;
        v.fl = fl; v.iv = iv; v.sel = sel; v.op = op; v.id = id; v.rdy = rdy;
        v.e_stb = e_stb; v.e_uns = e_uns; v.e_rdy = e_rdy; v.e_id = e_id;
        v.e_stall = e_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic iv, input logic [2:0] sel,
                         input logic [7:0] op, input logic [2:0] id, input logic rdy);
        fu_data_t d;
        d           = '0;
        d.operation = op;
        d.operand_a = 64'(100 + int'(id));
        d.trans_id  = id;
        flush_i         = fl;
        issue_valid_i   = iv;
        issue_sel_i     = sel;
        issue_fu_data_i = d;
        flu_ready_i     = rdy;
    endtask

    function automatic logic [4:0] strobes();
        return {alu_valid_o, branch_valid_o, csr_valid_o, mult_valid_o, valu_valid_o};
    endfunction

    task automatic chk_data(input string tag, input logic [2:0] e_id);
        chk({tag, " trans_id"}, 64'(fu_data_o.trans_id), 64'(e_id));
        chk({tag, " operand_a"}, fu_data_o.operand_a, (e_id == 3'd0) ? 64'd0 : 64'(100 + int'(e_id)));
    endtask

    initial begin
        // ---------------- table ----------------
        //             fl iv sel         op      id rdy  stb    uns  rdy  eid st
        vecs.push_back(mk(0, 1, FLU_ALU,    OP_ADD, 3, 1, S_NO,  0,   1,   0,  0));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_ALU, 0,   1,   3,  0));
        vecs.push_back(mk(0, 1, FLU_MULT,   OP_MUL, 1, 1, S_NO,  0,   1,   0,  0));
        vecs.push_back(mk(0, 1, FLU_ALU,    OP_ADD, 2, 1, S_MUL, 0,   1,   1,  0));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_NO,  0,   0,   2,  0));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_ALU, 0,   1,   2,  1));
        vecs.push_back(mk(0, 1, FLU_MULT,   OP_MUL, 4, 1, S_NO,  0,   1,   0,  1));
        vecs.push_back(mk(0, 1, FLU_MULT,   OP_MUL, 5, 1, S_MUL, 0,   1,   4,  1));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_MUL, 0,   1,   5,  1));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_NO,  0,   1,   0,  1));
        vecs.push_back(mk(0, 1, FLU_CSR,    OP_ADD, 6, 1, S_NO,  0,   1,   0,  1));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(0, 1, FLU_ALU, OP_ADD, 7, 0, S_NO, 0, 0, 6, 1 + k));
        vecs.push_back(mk(0, 1, FLU_ALU,    OP_ADD, 7, 1, S_CSR, 0,   1,   6,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_ALU, 0,   1,   7,  5));
        vecs.push_back(mk(0, 1, FLU_MULT,   OP_MUL, 1, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 1, FLU_ALU,    OP_ADD, 2, 1, S_MUL, 0,   1,   1,  5));
        vecs.push_back(mk(1, 1, FLU_ALU,    OP_ADD, 3, 1, S_NO,  0,   0,   2,  5));
        vecs.push_back(mk(0, 1, FLU_ALU,    OP_ADD, 3, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_ALU, 0,   1,   3,  5));
        vecs.push_back(mk(0, 1, FLU_BRANCH, OP_ADD, 2, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_BR,  0,   1,   2,  5));
        vecs.push_back(mk(0, 1, FLU_VALU,   OP_ADD, 5, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_VALU, U_VALU, 1, 5, 5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 1, 3'd6,       OP_ADD, 4, 1, S_NO,  0,   1,   0,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_NO,  1,   1,   4,  5));
        vecs.push_back(mk(0, 0, FLU_ALU,    OP_ADD, 0, 1, S_NO,  0,   1,   0,  5));

        // ---------------- reset state ----------------
        drive(0, 0, FLU_ALU, OP_ADD, 0, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("rst strobes", 64'(strobes()), 64'(S_NO));
        chk("rst unsupported", 64'(unsupported_o), 64'd0);
        chk("rst issue_ready", 64'(issue_ready_o), 64'd1);
        chk("rst fu_data", 64'(fu_data_o.trans_id) | fu_data_o.operand_a, 64'd0);
        chk("rst stall_cnt", 64'(stall_cnt_o), 64'd0);

        // ---------------- table application ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clk_i);
            drive(vecs[i].fl, vecs[i].iv, vecs[i].sel, vecs[i].op, vecs[i].id, vecs[i].rdy);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, " strobes"}, 64'(strobes()), 64'(vecs[i].e_stb));
            chk({tag, " unsupported"}, 64'(unsupported_o), 64'(vecs[i].e_uns));
            chk({tag, " unsup_id"}, 64'(unsupported_trans_id_o),
                vecs[i].e_uns ? 64'(vecs[i].e_id) : 64'd0);
            chk({tag, " issue_ready"}, 64'(issue_ready_o), 64'(vecs[i].e_rdy));
            chk_data(tag, vecs[i].e_id);
            chk({tag, " stall_cnt"}, 64'(stall_cnt_o), 64'(vecs[i].e_stall));
        end

        // ---------------- reset while holding a staged op ----------------
        @(negedge clk_i);
        drive(0, 1, FLU_CSR, OP_ADD, 6, 0);
        @(negedge clk_i);
        drive(0, 0, FLU_ALU, OP_ADD, 0, 0);
        #1;
        chk("hold staged id", 64'(fu_data_o.trans_id), 64'd6);
        chk("hold strobes", 64'(strobes()), 64'(S_NO));
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        flu_ready_i = 1'b1;
        #1;
        chk("midrst strobes", 64'(strobes()), 64'(S_NO));
        chk("midrst issue_ready", 64'(issue_ready_o), 64'd1);
        chk_data("midrst", 3'd0);
        chk("midrst stall_cnt", 64'(stall_cnt_o), 64'd0);

        // ---------------- division does not open a collision window ----------------
        @(negedge clk_i);
        drive(0, 1, FLU_MULT, OP_DIV, 1, 1);
        @(negedge clk_i);
        drive(0, 1, FLU_ALU, OP_ADD, 2, 1);
        #1;
        chk("div strobes", 64'(strobes()), 64'(S_MUL));
        @(negedge clk_i);
        drive(0, 0, FLU_ALU, OP_ADD, 0, 1);
        #1;
        chk("post-div alu strobes", 64'(strobes()), 64'(S_ALU));
        chk_data("post-div", 3'd2);
        chk("post-div stall_cnt", 64'(stall_cnt_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
